// File: rtl/maxpool2x2_stream.sv
// maxpool2x2_stream: streaming 2x2 / stride-2 signed max-pool.
// Pixels arrive in raster order. Each even row leaves its pooled pairs in a
// half-width line buffer. The following odd row completes each 2x2 window
// and emits one pooled pixel through a one-entry output register.
// Optional feature: define POOL_RELU_EN to clamp negative inputs to zero
// before pooling.
module maxpool2x2_stream #(
  parameter int DATA_W = 16,
  parameter int IMG_W  = 26,
  parameter int IMG_H  = 26
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  // Line-buffer address is the column index with its LSB dropped.
  localparam int LB_AW = (COL_W > 1) ? COL_W - 1 : 1;
  localparam int LB_D  = 2 ** LB_AW;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [COL_W-1:0]        col;
  logic [ROW_W-1:0]        row;
  logic signed [DATA_W-1:0] hold;
  logic signed [DATA_W-1:0] pix;
  logic signed [DATA_W-1:0] lbuf [0:LB_D-1];
  logic [LB_AW-1:0]        lb_idx;
  logic                    accept;
  logic                    out_fire;
  logic                    col_last;
  logic                    row_last;
  logic                    last_beat;
  logic                    lb_write;
  logic                    pool_now;
  logic                    pool_last;

  function automatic logic signed [DATA_W-1:0] smax(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

  assign in_ready  = (state == S_RUN) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign col_last  = (col == COL_W'(IMG_W - 1));
  assign row_last  = (row == ROW_W'(IMG_H - 1));
  assign last_beat = accept && col_last && row_last;
  assign lb_idx    = LB_AW'(col >> 1);
  // Odd column completes a pair: even rows park it, odd rows finish the window.
  assign lb_write  = accept && col[0] && !row[0];
  assign pool_now  = accept && col[0] && row[0];
  assign pool_last = (row == ROW_W'(2 * (IMG_H / 2) - 1)) &&
                     (col == COL_W'(2 * (IMG_W / 2) - 1));

  // Input pixel conditioning (optional ReLU clamp).
  always_comb begin
    pix = $signed(in_data);
`ifdef POOL_RELU_EN
    if (in_data[DATA_W-1]) begin
      pix = '0;
    end else begin
      pix = $signed(in_data);
    end
`endif
  end

  // Next-state logic for the frame sequencer.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_RUN;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (last_beat) begin
          state_nxt = S_DRAIN;
        end else begin
          state_nxt = S_RUN;
        end
      end
      S_DRAIN: begin
        if (!out_valid) begin
          state_nxt = S_DONE;
        end else begin
          state_nxt = S_DRAIN;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register with busy/done registered from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != S_IDLE);
      done  <= (state_nxt == S_DONE);
    end
  end

  // Raster position counters; cleared when a frame is armed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (state == S_IDLE && start) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

  // Left pixel of the current horizontal pair.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold <= '0;
    end else if (accept && !col[0]) begin
      hold <= pix;
    end
  end

  // Line buffer of pooled even-row pairs; contents need no reset.
  always_ff @(posedge clk) begin
    if (lb_write) begin
      lbuf[lb_idx] <= smax(hold, pix);
    end
  end

  // One-entry output register; a new result may load in the same cycle
  // the previous one is taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (pool_now) begin
      out_data  <= smax(lbuf[lb_idx], smax(hold, pix));
      out_valid <= 1'b1;
      out_last  <= pool_last;
    end else if (out_fire) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Self-checking bench for maxpool2x2_stream: a 4x4 and a 5x5 instance share
// stimulus; sel picks which one is armed and observed. Expected pooled
// values come from a direct 2x2-window max over the generated frame.
module tb_maxpool2x2_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] in_data;
  logic        in_valid;
  logic        out_ready;
  logic        sel;

  logic        ir4, ov4, ol4, b4, d4;
  logic [15:0] od4;
  logic        ir5, ov5, ol5, b5, d5;
  logic [15:0] od5;
  logic        start4, start5;

  logic        in_ready, out_valid, out_last, busy, done;
  logic [15:0] out_data;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign start4    = start && !sel;
  assign start5    = start && sel;
  assign in_ready  = sel ? ir5 : ir4;
  assign out_valid = sel ? ov5 : ov4;
  assign out_last  = sel ? ol5 : ol4;
  assign busy      = sel ? b5  : b4;
  assign done      = sel ? d5  : d4;
  assign out_data  = sel ? od5 : od4;

  maxpool2x2_stream #(.DATA_W(16), .IMG_W(4), .IMG_H(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .in_data(in_data), .in_valid(in_valid),
    .in_ready(ir4), .out_data(od4), .out_valid(ov4), .out_ready(out_ready),
    .out_last(ol4), .busy(b4), .done(d4)
  );

  maxpool2x2_stream #(.DATA_W(16), .IMG_W(5), .IMG_H(5)) u_dut5 (
    .clk(clk), .rst(rst), .start(start5), .in_data(in_data), .in_valid(in_valid),
    .in_ready(ir5), .out_data(od5), .out_valid(ov5), .out_ready(out_ready),
    .out_last(ol5), .busy(b5), .done(d5)
  );

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int cond(input logic signed [15:0] v);
`ifdef POOL_RELU_EN
    return (v < 0) ? 0 : int'(v);
`else
    return int'(v);
`endif
  endfunction

  // pat: 0 ramp, 1 all -3, 2 random. rmode: 0 ready, 1 stall 5 after first
  // output, 2 random ready/valid. restart_at: cycle of a stray start pulse.
  // abort_after: return once that many beats are accepted (0 = full frame).
  task automatic run_frame(input int w, input int h, input int pat, input int rmode,
                           input int restart_at, input int abort_after);
    logic signed [15:0] img [0:24];
    int exp_q [$];
    int idx, nout, cyc, stall, e, m, v;
    bit first_seen, acc_in, acc_out, got_done;
    for (int i = 0; i < w * h; i++) begin
      case (pat)
        0:       img[i] = 16'(i);
        1:       img[i] = -16'sd3;
        default: img[i] = 16'($urandom);
      endcase
    end
    for (int r = 0; r < h / 2; r++) begin
      for (int c = 0; c < w / 2; c++) begin
        m = cond(img[2*r*w + 2*c]);
        for (int k = 0; k < 4; k++) begin
          v = cond(img[(2*r + k/2)*w + 2*c + k%2]);
          if (v > m) m = v;
        end
        exp_q.push_back(m);
      end
    end
    sel = (w == 5);
    idx = 0; nout = 0; cyc = 0; stall = 0; first_seen = 0; got_done = 0;
    while (cyc < 600) begin
      @(negedge clk);
      if (done) begin
        got_done = 1;
        break;
      end
      if (out_valid) begin
        if (exp_q.size() > 0) check("out_vs_model", $signed(out_data), exp_q[0]);
        else check("unexpected_out_valid", 1, 0);
      end
      start = (cyc == 0) || (cyc == restart_at);
      if (idx < w * h) begin
        in_valid = (rmode == 2) ? ($urandom_range(3) != 0) : 1'b1;
        in_data  = img[idx];
      end else begin
        in_valid = 1'b0;
        in_data  = 16'h0;
      end
      if (rmode == 1) begin
        if (out_valid && !first_seen) begin
          first_seen = 1;
          stall = 5;
        end
        out_ready = (stall == 0);
        if (stall > 0) stall--;
      end else if (rmode == 2) begin
        out_ready = ($urandom_range(2) != 0);
      end else begin
        out_ready = 1'b1;
      end
      #1;
      if (out_valid && !out_ready) check("in_ready_while_stalled", in_ready, 0);
      acc_in  = in_valid && in_ready;
      acc_out = out_valid && out_ready;
      if (acc_out) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 99999;
        check("pooled_pixel", $signed(out_data), e);
        check("out_last", out_last, (exp_q.size() == 0));
        nout++;
      end
      if (acc_in) idx++;
      cyc++;
      if (abort_after > 0 && idx == abort_after) return;
    end
    start = 1'b0;
    in_valid = 1'b0;
    if (!got_done) begin
      check("timeout_waiting_done", 0, 1);
      return;
    end
    check("outputs_delivered", nout, (w / 2) * (h / 2));
    check("inputs_accepted", idx, w * h);
    check("busy_with_done", busy, 1);
    check("out_valid_at_done", out_valid, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("done_one_cycle", done, 0);
      check("busy_after_done", busy, 0);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 16'h0;
    out_ready = 1'b1; sel = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out_data", out_data, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b0;
    @(negedge clk);

    run_frame(4, 4, 0, 0, -1, 0);   // ramp
    run_frame(4, 4, 1, 0, -1, 0);   // all -3
    run_frame(4, 4, 0, 1, -1, 0);   // backpressure
    run_frame(5, 5, 0, 0, -1, 0);   // odd size

    // Mid-frame reset.
    run_frame(4, 4, 0, 0, -1, 9);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_in_ready", in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_frame(4, 4, 0, 0, -1, 0);

    run_frame(4, 4, 0, 0, 5, 0);    // stray start during RUN
    run_frame(5, 5, 2, 0, 7, 0);

    for (int k = 0; k < 8; k++) begin
      run_frame((k % 2) ? 5 : 4, (k % 2) ? 5 : 4, 2, 2, -1, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
